// File: rtl/code_entry_seq.sv
// code_entry_seq: pushbutton code entry in front of the motor-unlock checker.
// Buttons are synchronized and debounced into single-cycle press pulses.
// The FSM assembles five bits, presents them for a fixed hold window, and
// reads the checker's unlock result back to count failures. Repeated
// failures trigger a timed lockout.
//
// Handshake note: there is no valid/ready pair here. code_valid is a
// qualifier only. The checker has no way to stall the presentation. It
// answers through unlock, which is sampled once, on the final hold cycle.

// Per-button front end: 2-flop synchronizer, debounce, rising-edge pulse.
module code_entry_seq_btn #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  // Pulse only when the accepted level rises.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      pulse_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// Top: code entry sequencer.
module code_entry_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_zero,
  input  logic       btn_one,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       unlock,
  output logic [4:0] code,
  output logic       code_valid,
  output logic [2:0] digit_count,
  output logic [1:0] fail_count,
  output logic       locked,
  output logic [1:0] dbg_state_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    FAIL_LAST = 2'(MAX_FAILS - 1);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    shreg_q, shreg_d;
  logic [2:0]    digit_q, digit_d;
  logic [1:0]    fail_q, fail_d;
  logic [4:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  logic zero_p, one_p, enter_p, clear_p;
  logic dig_p, dig_bit;

  code_entry_seq_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_zero (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_zero), .pulse_o(zero_p)
  );
  code_entry_seq_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_one (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_one), .pulse_o(one_p)
  );
  code_entry_seq_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_enter (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_enter), .pulse_o(enter_p)
  );
  code_entry_seq_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_clear), .pulse_o(clear_p)
  );

  // A digit counts only when exactly one of zero/one pulses this cycle.
  assign dig_p   = zero_p ^ one_p;
  assign dig_bit = one_p;

  // Next-state and output logic. Clear is tested first so it wins over enter and digits.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    digit_d    = digit_q;
    fail_d     = fail_q;
    code_d     = code_q;
    valid_d    = valid_q;
    locked_d   = locked_q;
    hold_d     = hold_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ST_ENTRY: begin
        if (clear_p) begin
          shreg_d = '0;
          digit_d = '0;
        end else if (dig_p) begin
          shreg_d = {shreg_q[3:0], dig_bit};
          digit_d = digit_q + 3'd1;
          if (digit_q == 3'd4) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (clear_p) begin
          shreg_d = '0;
          digit_d = '0;
          state_d = ST_ENTRY;
        end else if (enter_p) begin
          code_d  = shreg_q;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (hold_q == HOLD_LAST) begin
          // Checker output lags code by one cycle, so it is valid only here.
          code_d  = '0;
          valid_d = 1'b0;
          shreg_d = '0;
          digit_d = '0;
          if (unlock) begin
            fail_d  = '0;
            state_d = ST_ENTRY;
          end else if (fail_q == FAIL_LAST) begin
            fail_d     = fail_q + 2'd1;
            locked_d   = 1'b1;
            lock_cnt_d = '0;
            state_d    = ST_LOCKOUT;
          end else begin
            fail_d  = fail_q + 2'd1;
            state_d = ST_ENTRY;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          locked_d = 1'b0;
          fail_d   = '0;
          state_d  = ST_ENTRY;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTRY;
      shreg_q    <= '0;
      digit_q    <= '0;
      fail_q     <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      hold_q     <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      digit_q    <= digit_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      hold_q     <= hold_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign code        = code_q;
  assign code_valid  = valid_q;
  assign digit_count = digit_q;
  assign fail_count  = fail_q;
  assign locked      = locked_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_code_entry_seq.sv
// tb_code_entry_seq: directed bench for code_entry_seq with a 10101-only checker model.
module tb_code_entry_seq;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int MAXF = 3;
  localparam int LOCK = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_zero = 1'b0, btn_one = 1'b0, btn_enter = 1'b0, btn_clear = 1'b0;
  logic       unlock;
  logic [4:0] code;
  logic       code_valid;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  logic       locked;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset.
  always #5 clk = ~clk;

  code_entry_seq #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_zero(btn_zero), .btn_one(btn_one), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .unlock(unlock), .code(code), .code_valid(code_valid), .digit_count(digit_count),
    .fail_count(fail_count), .locked(locked), .dbg_state_o(dbg_state)
  );

  // Downstream checker model: registered enable, accepts only 10101.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) unlock <= 1'b0;
    else        unlock <= code_valid && (code == 5'b10101);
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver: one debounced press of a digit button.
  task automatic press_digit(input logic b);
    if (b) btn_one = 1'b1; else btn_zero = 1'b1;
    cycles(8);
    btn_one = 1'b0;
    btn_zero = 1'b0;
    cycles(8);
  endtask

  // Driver: five digits, first digit is v[4]; digit_count checked after each.
  task automatic enter_code5(input logic [4:0] v);
    for (int i = 4; i >= 0; i--) begin
      press_digit(v[i]);
      check_eq("digit_count_step", 32'(digit_count), 32'(5 - i));
    end
  endtask

  // Press enter and score the whole presentation window.
  task automatic submit(input logic [4:0] exp_code, input logic exp_unl,
                        input logic [1:0] exp_fail, input logic exp_locked);
    logic seen, last_unl;
    int   len, bad;
    seen = 1'b0;
    btn_enter = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (code_valid) seen = 1'b1;
    end
    check_eq("enter_to_valid", 32'(seen), 32'd1);
    if (seen) begin
      check_eq("present_code", 32'(code), 32'(exp_code));
      len = 0; bad = 0; last_unl = 1'b0;
      while (code_valid && len < 40) begin
        len++;
        if (code !== exp_code) bad++;
        last_unl = unlock;
        @(negedge clk);
      end
      check_eq("hold_len", 32'(len), 32'(HOLD));
      check_eq("code_stable", 32'(bad), 32'd0);
      check_eq("unlock_last", 32'(last_unl), 32'(exp_unl));
      check_eq("post_code", 32'(code), 32'd0);
      check_eq("post_valid", 32'(code_valid), 32'd0);
      check_eq("post_digits", 32'(digit_count), 32'd0);
      check_eq("post_fail", 32'(fail_count), 32'(exp_fail));
      check_eq("post_locked", 32'(locked), 32'(exp_locked));
    end
    btn_enter = 1'b0;
  endtask

  initial begin
    int  len, bad;
    logic seen;

    // Reset values while held in reset.
    cycles(3);
    check_eq("rst_code", 32'(code), 32'd0);
    check_eq("rst_valid", 32'(code_valid), 32'd0);
    check_eq("rst_digits", 32'(digit_count), 32'd0);
    check_eq("rst_fail", 32'(fail_count), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Accepted code 10101.
    enter_code5(5'b10101);
    submit(5'b10101, 1'b1, 2'd0, 1'b0);
    cycles(8);

    // Bounce on btn_one gives one digit only; shreg=00001 shown by completing 0101.
    for (int k = 0; k < 3; k++) begin
      btn_one = 1'b1; cycles(2);
      btn_one = 1'b0; cycles(2);
    end
    check_eq("bounce_no_digit", 32'(digit_count), 32'd0);
    btn_one = 1'b1; cycles(10);
    btn_one = 1'b0; cycles(8);
    check_eq("bounce_one_digit", 32'(digit_count), 32'd1);
    press_digit(1'b0); press_digit(1'b1); press_digit(1'b0); press_digit(1'b1);
    check_eq("bounce_full", 32'(digit_count), 32'd5);
    submit(5'b10101, 1'b1, 2'd0, 1'b0);
    cycles(8);

    // Three failures then lockout.
    enter_code5(5'b11100);
    submit(5'b11100, 1'b0, 2'd1, 1'b0);
    cycles(8);
    enter_code5(5'b11100);
    submit(5'b11100, 1'b0, 2'd2, 1'b0);
    cycles(8);
    enter_code5(5'b11100);
    submit(5'b11100, 1'b0, 2'd3, 1'b1);
    len = 0; bad = 0;
    while (locked && len < 60) begin
      if (len == 2)  btn_one = 1'b1;
      if (len == 10) btn_one = 1'b0;
      if (len == 12) btn_zero = 1'b1;
      if (code !== 5'd0 || code_valid !== 1'b0 || digit_count !== 3'd0) bad++;
      len++;
      @(negedge clk);
    end
    check_eq("lock_len", 32'(len), 32'(LOCK));
    check_eq("lock_quiet", 32'(bad), 32'd0);
    check_eq("lock_exit_locked", 32'(locked), 32'd0);
    check_eq("lock_exit_fail", 32'(fail_count), 32'd0);
    cycles(6);
    check_eq("held_through_exit", 32'(digit_count), 32'd0);
    btn_zero = 1'b0;
    cycles(8);

    // Partial entry, enter ignored, clear, then valid code.
    press_digit(1'b1); press_digit(1'b0); press_digit(1'b1);
    btn_enter = 1'b1; cycles(8); btn_enter = 1'b0; cycles(8);
    check_eq("enter_at3_digits", 32'(digit_count), 32'd3);
    check_eq("enter_at3_valid", 32'(code_valid), 32'd0);
    btn_clear = 1'b1; cycles(8); btn_clear = 1'b0; cycles(8);
    check_eq("clear_digits", 32'(digit_count), 32'd0);
    enter_code5(5'b10101);
    submit(5'b10101, 1'b1, 2'd0, 1'b0);
    cycles(8);

    // Six digits, then clear with enter in FULL.
    enter_code5(5'b11001);
    press_digit(1'b0);
    check_eq("sixth_ignored", 32'(digit_count), 32'd5);
    btn_clear = 1'b1; btn_enter = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (code_valid) seen = 1'b1;
    end
    check_eq("clear_beats_enter", 32'(seen), 32'd0);
    check_eq("clear_full_digits", 32'(digit_count), 32'd0);
    btn_clear = 1'b0; btn_enter = 1'b0;
    cycles(8);

    // One failure, then reset during the 4th presentation cycle.
    enter_code5(5'b00111);
    submit(5'b00111, 1'b0, 2'd1, 1'b0);
    cycles(8);
    enter_code5(5'b10101);
    btn_enter = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (code_valid) seen = 1'b1;
    end
    check_eq("mid_present_valid", 32'(seen), 32'd1);
    cycles(3);
    check_eq("mid_present_fail_pre", 32'(fail_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_code", 32'(code), 32'd0);
    check_eq("async_rst_valid", 32'(code_valid), 32'd0);
    check_eq("async_rst_fail", 32'(fail_count), 32'd0);
    check_eq("async_rst_digits", 32'(digit_count), 32'd0);
    btn_enter = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(12);
    check_eq("after_rst_valid", 32'(code_valid), 32'd0);
    check_eq("after_rst_digits", 32'(digit_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/code_entry_seq.md
Name: code_entry_seq

Overview:
- Upstream stage of the motor-unlock code checker. The checker takes a 5-bit code and drives the motor enable and the 7-segment screen.
- This block collects a code one bit at a time from pushbuttons (ZERO, ONE, ENTER, CLEAR) and presents the assembled 5-bit code for a fixed hold window.
- It reads the checker's enable output back to count failed attempts, and enforces a lockout after repeated failures.
- While no code is being presented it drives 5'b00000, which the checker decodes as blank screen, motor off.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples before a button level is accepted.
- HOLD_CYCLES, 1000, number of cycles the code is presented downstream; must be ≥ 2.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout; range 1..3.
- LOCKOUT_CYCLES, 5000, lockout duration in cycles; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_zero  in  1  raw pushbutton, active-high, asynchronous: enter bit 0.
- btn_one  in  1  raw pushbutton, active-high, asynchronous: enter bit 1.
- btn_enter  in  1  raw pushbutton: submit code.
- btn_clear  in  1  raw pushbutton: discard digits.
- unlock  in  1  checker's registered enable output (1 = code accepted).
- code  out  5  code presented to checker.
- code_valid  out  1  high while code is being presented.
- digit_count  out  3  digits entered, 0..5.
- fail_count  out  2  consecutive failures.
- locked  out  1  high during lockout.

Behaviour:
- Reset (async, rst_n=0):
  - code=0, code_valid=0, digit_count=0, fail_count=0, locked=0.
  - Shift register 0, state ENTRY.
  - Synchronizers, debounce counters and accepted levels all 0.
- Button front end, per button:
  - 2-flop synchronizer, then a debounce counter. The accepted level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
  - A rising edge of the accepted level gives a 1-cycle pulse.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- Priority within a cycle:
  - clear beats enter and digit pulses.
  - zero and one pulsing together: both ignored.
- State ENTRY (digit_count < 5):
  - zero or one pulse: shreg <= {shreg[3:0], bit} (first digit ends up at code[4]), digit_count+1.
  - Reaching 5 moves to FULL.
  - enter: ignored.
  - clear: shreg=0, digit_count=0.
- State FULL (digit_count=5):
  - Digit pulses ignored; clear returns to ENTRY with shreg=0, count=0.
  - enter moves to PRESENT on the next cycle: code=shreg, code_valid=1, hold counter=0.
- State PRESENT:
  - Lasts exactly HOLD_CYCLES cycles. All button pulses are ignored.
  - The checker registers with 1-cycle latency, so unlock is sampled on the final hold cycle only.
  - On exit: code=0, code_valid=0, shreg=0, digit_count=0.
  - If unlock was 1: fail_count=0, go to ENTRY.
  - If unlock was 0: fail_count+1. Reaching MAX_FAILS goes to LOCKOUT, otherwise ENTRY.
- State LOCKOUT:
  - locked=1 for LOCKOUT_CYCLES cycles; all pulses ignored; code=0.
  - On exit: locked=0, fail_count=0, go to ENTRY.
  - A button held through the exit does not generate a pulse; only a fresh rising edge counts.
- Output rules:
  - code is nonzero only while code_valid=1.
  - All outputs are registered.
- Reset mid-operation: an immediate async return to reset values, including mid-PRESENT and mid-LOCKOUT.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, MAX_FAILS=3, LOCKOUT_CYCLES=20. The checker model accepts only 10101.
- Digits 1,0,1,0,1, then enter -> digit_count steps 1..5. code=5'b10101 with code_valid=1 for exactly 8 cycles; unlock observed; fail_count stays 0; then code=0, digit_count=0.
- btn_one bounce of 2-cycle pulses, then held 10 cycles -> exactly one digit accepted; digit_count=1, shreg=00001.
- Digits 1,1,1,0,0 plus enter, three times -> fail_count 1, 2, then locked=1 for 20 cycles. Buttons pressed during lockout are ignored. After lockout, locked=0 and fail_count=0.
- Entry 1,0,1 then clear, then 1,0,1,0,1 plus enter -> presented code 10101. Enter pressed at digit_count=3 has no effect.
- Six digits, then clear pressed together with enter in FULL -> sixth digit ignored; clear wins; no presentation; digit_count=0.
- rst_n asserted low mid-PRESENT (cycle 4) -> code=0, code_valid=0, fail_count=0 immediately, without waiting for a clock edge.
